// File: rtl/uart_calc_core.sv
// uart_calc_core: parses "<op1><+|-|*><op2>=" from rx bytes, computes the result and streams
// it back as decimal ASCII followed by CR LF, or "E" CR LF on malformed input.
module uart_calc_core #(
  parameter int MAX_DIGITS = 4,
  parameter int OPW        = 14,
  parameter int RES_DIGITS = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);
  localparam int RW = $clog2(10**RES_DIGITS);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int KW = $clog2(RES_DIGITS);
  localparam int BL = RES_DIGITS + 3;
  localparam int LW = $clog2(BL + 1);
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;
  typedef enum logic [2:0] {OP1, OP2, CALC, CONV, SEND, FLUSH} state_t;
  typedef enum logic [1:0] {ADD, SUB, MUL} opc_t;
  state_t state_q, state_d;
  opc_t opc_q, opc_d;
  logic [OPW-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] res_q, res_d, p, a, b;
  logic [KW-1:0] k_q, k_d;
  logic [3:0] dig_q, dig_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [7:0] obuf_q [BL], obuf_d [BL];
  logic [7:0] tx_data_q, tx_data_d;
  logic neg_q, neg_d, started_q, started_d, flush_q, flush_d, tx_valid_q, tx_valid_d, busy_q, busy_d;
  logic fault, clr, is_dig, is_op, is_clr, is_eq;
  function automatic logic [RW-1:0] pow10(input logic [KW-1:0] k);
    logic [RW-1:0] r;
    r = RW'(1);
    for (int i = 0; i < RES_DIGITS; i++) r = (i < int'(k)) ? r * RW'(10) : r;
    return r;
  endfunction
  always_comb begin
    state_d = state_q;
    opc_d = opc_q;
    op1_d = op1_q;
    op2_d = op2_q;
    cnt_d = cnt_q;
    res_d = res_q;
    k_d = k_q;
    dig_d = dig_q;
    len_d = len_q;
    idx_d = idx_q;
    obuf_d = obuf_q;
    tx_data_d = tx_data_q;
    neg_d = neg_q;
    started_d = started_q;
    flush_d = flush_q;
    tx_valid_d = tx_valid_q;
    fault = 1'b0;
    clr = 1'b0;
    is_dig = rx_data inside {[8'h30:8'h39]};
    is_op = rx_data inside {"+", "-", "*"};
    is_clr = rx_data inside {"c", "C"};
    is_eq = rx_data == "=";
    a = RW'(op1_q);
    b = RW'(op2_q);
    p = pow10(k_q);
    case (state_q)
      OP1, OP2: if (rx_valid) begin
        if (is_dig) begin
          if (cnt_q == CW'(MAX_DIGITS)) fault = 1'b1;
          else begin
            cnt_d = cnt_q + CW'(1);
            if (state_q == OP1) op1_d = op1_q * OPW'(10) + OPW'(rx_data[3:0]);
            else op2_d = op2_q * OPW'(10) + OPW'(rx_data[3:0]);
          end
        end
        else if (rx_data == " " || (state_q == OP1 && cnt_q == '0 && (rx_data == CR || rx_data == LF))) ;
        else if (is_clr) clr = 1'b1;
        else if (state_q == OP1 && is_op && cnt_q != '0) begin
          opc_d = rx_data == "+" ? ADD : rx_data == "-" ? SUB : MUL;
          cnt_d = '0;
          state_d = OP2;
        end
        else if (state_q == OP2 && is_eq && cnt_q != '0) state_d = CALC;
        else fault = 1'b1;
      end
      CALC: begin
        neg_d = opc_q == SUB && op1_q < op2_q;
        res_d = opc_q == ADD ? a + b : opc_q == MUL ? a * b : neg_d ? b - a : a - b;
        obuf_d[0] = "-";
        len_d = LW'(neg_d);
        k_d = KW'(RES_DIGITS - 1);
        dig_d = '0;
        started_d = 1'b0;
        state_d = CONV;
      end
      CONV: begin
        if (res_q >= p) begin
          res_d = res_q - p;
          dig_d = dig_q + 4'd1;
        end
        else begin
          // the ones digit is always emitted so a zero result still prints "0"
          if (started_q || dig_q != '0 || k_q == '0) begin
            obuf_d[len_q] = 8'h30 + {4'd0, dig_q};
            len_d = len_q + LW'(1);
            started_d = 1'b1;
          end
          dig_d = '0;
          k_d = k_q - KW'(1);
          if (k_q == '0) begin
            obuf_d[len_q + LW'(1)] = CR;
            obuf_d[len_q + LW'(2)] = LF;
            len_d = len_q + LW'(3);
            idx_d = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d = obuf_q[idx_q];
        end
        else if (tx_ready) begin
          tx_valid_d = 1'b0;
          idx_d = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) begin
            state_d = flush_q ? FLUSH : OP1;
            flush_d = 1'b0;
            op1_d = '0;
            op2_d = '0;
            cnt_d = '0;
          end
        end
      end
      FLUSH: if (rx_valid) begin
        if (is_eq || rx_data == CR) state_d = OP1;
        else if (is_clr) clr = 1'b1;
      end
      default: ;
    endcase
    if (clr) begin
      op1_d = '0;
      op2_d = '0;
      cnt_d = '0;
      state_d = OP1;
    end
    if (fault) begin
      obuf_d[0] = "E";
      obuf_d[1] = CR;
      obuf_d[2] = LF;
      len_d = LW'(3);
      idx_d = '0;
      flush_d = !is_eq;
      op1_d = '0;
      op2_d = '0;
      cnt_d = '0;
      state_d = SEND;
    end
    busy_d = state_d inside {CALC, CONV, SEND};
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= OP1;
      opc_q <= ADD;
      op1_q <= '0;
      op2_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      k_q <= '0;
      dig_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      obuf_q <= '{default: '0};
      tx_data_q <= '0;
      neg_q <= 1'b0;
      started_q <= 1'b0;
      flush_q <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end
    else begin
      state_q <= state_d;
      opc_q <= opc_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      k_q <= k_d;
      dig_q <= dig_d;
      len_q <= len_d;
      idx_q <= idx_d;
      obuf_q <= obuf_d;
      tx_data_q <= tx_data_d;
      neg_q <= neg_d;
      started_q <= started_d;
      flush_q <= flush_d;
      tx_valid_q <= tx_valid_d;
      busy_q <= busy_d;
    end
  end
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_calc_core.sv
// tb_uart_calc_core: table of input strings and expected tx byte strings, plus stall and reset sequences.
module tb_uart_calc_core;
  localparam logic [15:0] CRLF = 16'h0d0a;
  localparam int NV = 18;
  typedef struct packed {
    logic [127:0] in;
    logic [127:0] exp;
  } vec_t;
  logic clk, n_rst, rx_valid, tx_valid, tx_ready, busy;
  logic [7:0] rx_data, tx_data;
  logic [7:0] txq [$];
  logic herr;
  int checks, passed;
  vec_t vt [NV];
  uart_calc_core dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    logic pv, px;
    logic [7:0] pd;
    herr = 1'b0;
    pv = 1'b0;
    px = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pv = 1'b0;
        px = 1'b0;
      end
      else begin
        if (px && tx_valid) herr = 1'b1;
        if (pv && (!tx_valid || tx_data !== pd)) herr = 1'b1;
        if (tx_valid && tx_ready && !busy) herr = 1'b1;
        pv = tx_valid && !tx_ready;
        px = tx_valid && tx_ready;
        pd = tx_data;
        if (px) txq.push_back(tx_data);
      end
    end
  end
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask
  function automatic logic [127:0] gotv(input int base);
    logic [127:0] r;
    r = '0;
    for (int i = base; i < txq.size(); i++) r = {r[119:0], txq[i]};
    return r;
  endfunction
  function automatic int nb(input logic [127:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (v[i*8 +: 8] != 8'h00) n++;
    return n;
  endfunction
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) chk("busy_wait", 128'(busy), 128'(0));
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask
  task automatic send_str(input logic [127:0] s);
    for (int i = 15; i >= 0; i--) if (s[i*8 +: 8] != 8'h00) send_byte(s[i*8 +: 8]);
  endtask
  task automatic wait_idle();
    int idle, n;
    idle = 0;
    n = 0;
    while (idle < 3 && n < 1000) begin
      @(posedge clk);
      #1;
      idle = (!busy && !tx_valid) ? idle + 1 : 0;
      n++;
    end
    chk("idle", 128'(idle >= 3), 128'(1));
  endtask
  task automatic chk_out(input string name, input int base, input logic [127:0] exp);
    chk(name, gotv(base), exp);
    chk({name, "_len"}, 128'(txq.size() - base), 128'(nb(exp)));
  endtask
  initial begin
    int base, n;
    logic [7:0] d0;
    logic stable;
    checks = 0;
    passed = 0;
    vt[0] = '{128'("12+34="), 128'({"46", CRLF})};
    vt[1] = '{128'("5-9="), 128'({"-4", CRLF})};
    vt[2] = '{128'("0*7="), 128'({"0", CRLF})};
    vt[3] = '{128'("9999*9999="), 128'({"99980001", CRLF})};
    vt[4] = '{128'("12345+1="), 128'({"E", CRLF})};
    vt[5] = '{128'("2+2="), 128'({"4", CRLF})};
    vt[6] = '{128'("+3="), 128'({"E", CRLF})};
    vt[7] = '{128'("1+1="), 128'({"2", CRLF})};
    vt[8] = '{128'("1 2+3="), 128'({"15", CRLF})};
    vt[9] = '{128'("7+c3*3="), 128'({"9", CRLF})};
    vt[10] = '{128'("=5+5="), 128'({"E", CRLF, "10", CRLF})};
    vt[11] = '{128'({8'h0d, "12+1="}), 128'({"13", CRLF})};
    vt[12] = '{128'("9-9="), 128'({"0", CRLF})};
    vt[13] = '{128'("1000*1000="), 128'({"1000000", CRLF})};
    vt[14] = '{128'("5+5C8-3="), 128'({"5", CRLF})};
    vt[15] = '{128'("1+=3*3="), 128'({"E", CRLF, "9", CRLF})};
    vt[16] = '{128'("9*9x7=2*3="), 128'({"E", CRLF, "6", CRLF})};
    vt[17] = '{128'("9999+9999="), 128'({"19998", CRLF})};
    n_rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 128'(tx_valid), 128'(0));
    chk("rst_tx_data", 128'(tx_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      base = txq.size();
      send_str(vt[i].in);
      wait_idle();
      chk_out($sformatf("vec%0d", i), base, vt[i].exp);
      chk($sformatf("vec%0d_handshake", i), 128'(herr), 128'(0));
    end
    base = txq.size();
    send_str("3+4=");
    chk("busy_after_eq", 128'(busy), 128'(1));
    wait_idle();
    chk("busy_after_lf", 128'(busy), 128'(0));
    chk_out("busy_seq", base, 128'({"7", CRLF}));
    tx_ready = 1'b0;
    base = txq.size();
    send_str("9999*9999=");
    n = 0;
    while (!tx_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    d0 = tx_data;
    stable = tx_valid;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (!tx_valid || tx_data !== d0) stable = 1'b0;
    end
    chk("stall_hold", 128'(stable), 128'(1));
    chk("stall_first", 128'(d0), 128'("9"));
    tx_ready = 1'b1;
    wait_idle();
    chk_out("stall_out", base, 128'({"99980001", CRLF}));
    chk("stall_handshake", 128'(herr), 128'(0));
    base = txq.size();
    send_str("9999*9999=");
    n = 0;
    while (txq.size() < base + 3 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pre_rst_valid", 128'(tx_valid), 128'(1));
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_tx_valid", 128'(tx_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_tx_data", 128'(tx_data), 128'(0));
    repeat (2) @(posedge clk);
    #3;
    n_rst = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    base = txq.size();
    send_str("1+1=");
    wait_idle();
    chk_out("post_rst", base, 128'({"2", CRLF}));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
